// File: rtl/csa_mult_sequencer_pkg.sv
// mult_seq_pkg: shared state encoding and counter sizing for the CSA multiplier sequencer
package mult_seq_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} mseq_state_e;
  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/csa_mult_sequencer_csa_row.sv
// csa_row: 3:2 compressor, one full-adder cell per bit; carry left unshifted
module csa_row #(
  parameter int N = 32
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  output logic [N-1:0] s,
  output logic [N-1:0] c
);
  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);
endmodule

// File: rtl/csa_mult_sequencer.sv
// csa_mult_sequencer: shift-add unsigned multiplier, one partial product per cycle into a
// carry-save accumulator, resolved by a single final add
module csa_mult_sequencer
  import mult_seq_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit EARLY_TERM = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   op_a_i,
  input  logic [WIDTH-1:0]   op_b_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               busy_o
);
  localparam int CW = cnt_w(WIDTH);
  mseq_state_e        r_state;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [2*WIDTH-1:0] r_sum, r_carry, r_result;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] w_pp, w_s, w_c;
  logic               w_last;
  assign w_pp = r_b[r_cnt] ? ({{WIDTH{1'b0}}, r_a} << r_cnt) : '0;
  // early exit once no set multiplier bits remain above the current one
  assign w_last = (r_cnt == CW'(WIDTH - 1)) ||
                  (EARLY_TERM && ((r_b >> (32'(r_cnt) + 32'd1)) == '0));
  csa_row #(.N(2 * WIDTH)) u_csa (
    .x(r_sum),
    .y(r_carry),
    .z(w_pp),
    .s(w_s),
    .c(w_c)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sum    <= '0;
      r_carry  <= '0;
      r_result <= '0;
      r_cnt    <= '0;
    end else if (flush_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid_i) begin
          r_a     <= op_a_i;
          r_b     <= op_b_i;
          r_sum   <= '0;
          r_carry <= '0;
          r_cnt   <= '0;
          r_state <= ACCUM;
        end
        ACCUM: begin
          r_sum   <= w_s;
          r_carry <= w_c << 1;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) r_state <= RESOLVE;
        end
        RESOLVE: begin
          r_result <= r_sum + r_carry;
          r_state  <= DONE;
        end
        DONE: if (out_ready_i) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign in_ready_o  = (r_state == IDLE);
  assign out_valid_o = (r_state == DONE);
  assign busy_o      = (r_state != IDLE);
  assign result_o    = r_result;
endmodule

// File: tb/tb_csa_mult_sequencer.sv
// tb_csa_mult_sequencer: full-latency and early-terminating instances driven in lockstep,
// checked against plain A*B and a highest-set-bit latency model
module tb_csa_mult_sequencer;
  localparam int W = 16;
  logic clk, rst_n, flush, in_valid, out_ready;
  logic [W-1:0] op_a, op_b;
  logic in_ready, out_valid, busy, e_in_ready, e_out_valid, e_busy;
  logic [2*W-1:0] result, e_result;
  int n_chk = 0, n_pass = 0;

  csa_mult_sequencer #(.WIDTH(W), .EARLY_TERM(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_a_i(op_a), .op_b_i(op_b), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .busy_o(busy)
  );
  csa_mult_sequencer #(.WIDTH(W), .EARLY_TERM(1'b1)) dut_et (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(e_in_ready),
    .op_a_i(op_a), .op_b_i(op_b), .out_valid_o(e_out_valid), .out_ready_i(out_ready),
    .result_o(e_result), .busy_o(e_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    int             lat;
    int             lat_e;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic int et_lat(input logic [W-1:0] b);
    for (int i = W - 1; i >= 0; i--) if (b[i]) return i + 2;
    return 2;
  endfunction

  task automatic chk_idle(input string nm);
    chk({nm, "_in_ready"}, {in_ready, e_in_ready}, 2'b11);
    chk({nm, "_out_valid"}, {out_valid, e_out_valid}, 2'b00);
    chk({nm, "_busy"}, {busy, e_busy}, 2'b00);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] p,
                       input int lat, input int lat_e, input int hold);
    int vm, ve;
    @(negedge clk);
    chk("accept_ready", {in_ready, e_in_ready}, 2'b11);
    in_valid = 1'b1; op_a = a; op_b = b; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    vm = -1; ve = -1;
    for (int k = 0; k < 60; k++) begin
      if (vm < 0 && out_valid) vm = k;
      if (ve < 0 && e_out_valid) ve = k;
      if (vm >= 0 && ve >= 0) break;
      @(negedge clk);
    end
    chk("latency", 64'(vm), 64'(lat));
    chk("latency_et", 64'(ve), 64'(lat_e));
    chk("result", result, p);
    chk("result_et", e_result, p);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; op_a = W'($urandom); op_b = W'($urandom);
      @(negedge clk);
      chk("hold_valid", {out_valid, e_out_valid, in_ready, e_in_ready}, 4'b1100);
      chk("hold_result", {result, e_result}, {p, p});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk_idle("post_handshake");
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0;
    #1;
    chk_idle("reset");
    chk("reset_result", {result, e_result}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    tbl[0] = '{16'h0003, 16'h0005, 32'h0000000F, 17, 4};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 17, 17};
    tbl[2] = '{16'h8000, 16'h8000, 32'h40000000, 17, 17};
    tbl[3] = '{16'h1234, 16'h0001, 32'h00001234, 17, 2};
    tbl[4] = '{16'h1234, 16'h0000, 32'h00000000, 17, 2};
    tbl[5] = '{16'h0000, 16'hFFFF, 32'h00000000, 17, 17};
    tbl[6] = '{16'h0001, 16'h8000, 32'h00008000, 17, 17};
    tbl[7] = '{16'hFFFF, 16'h0002, 32'h0001FFFE, 17, 3};
    foreach (tbl[i]) do_op(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].lat, tbl[i].lat_e, 5);

    // flush while the counter reads 7
    @(negedge clk);
    in_valid = 1'b1; op_a = 16'h1234; op_b = 16'hF0F0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk_idle("flush_mid");
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid || e_out_valid) seen++;
    end
    chk("flush_no_valid", 64'(seen), 64'd0);
    do_op(16'd2, 16'd9, 32'd18, 17, 5, 0);

    // flush and handshake together: nothing accepted
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op_a = 16'd5; op_b = 16'd5;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk_idle("flush_vs_accept");

    // flush in DONE drops the result but leaves result_o unchanged
    @(negedge clk);
    in_valid = 1'b1; op_a = 16'd11; op_b = 16'd13;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("done_before_flush", {out_valid, e_out_valid}, 2'b11);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk_idle("flush_done");
    chk("flush_done_result", {result, e_result}, {32'd143, 32'd143});

    // async reset mid-ACCUM
    @(negedge clk);
    in_valid = 1'b1; op_a = 16'h00FF; op_b = 16'h0F0F;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    chk("async_reset_result", {result, e_result}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid || e_out_valid) seen++;
    end
    chk("reset_no_valid", 64'(seen), 64'd0);
    do_op(16'd7, 16'd6, 32'd42, 17, 4, 1);

    for (int n = 0; n < 1500; n++) begin
      ra = W'($urandom);
      rb = W'($urandom >> $urandom_range(16, 31));
      do_op(ra, rb, 32'(ra) * 32'(rb), W + 1, et_lat(rb), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
